// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky error flags.
// Define FIFO_SYNC_V2_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module fifo_sync_v2 #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_ok_s, wr_ok_s;

  // A full FIFO can still take a write when the same cycle pops a word.
  always_comb begin
    rd_ok_s = rd & ~empty_q;
    wr_ok_s = wr & (~full_q | rd_ok_s);

    if (wr_ok_s) begin
      waddr_d = waddr_q + AW'(1);
    end else begin
      waddr_d = waddr_q;
    end

    if (rd_ok_s) begin
      raddr_d = raddr_q + AW'(1);
    end else begin
      raddr_d = raddr_q;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered from the next count so they change with count, glitch-free.
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == {CW{1'b0}});
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));

    if (wr & ~wr_ok_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rd & empty_q) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= {AW{1'b0}};
      raddr_q <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is never reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[waddr_q] <= din;
    end
  end

`ifdef FIFO_SYNC_V2_FWFT_EN
  assign dout = empty_q ? {WIDTH{1'b0}} : mem[raddr_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    if (rd_ok_s) begin
      dout_d = mem[raddr_q];
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= {WIDTH{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed bench for fifo_sync_v2 at WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_sync_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_sync_v2 #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic [7:0] dstd;
    logic [7:0] dfw;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input logic [2:0] c, input logic f, input logic e,
                         input logic af, input logic ae, input logic ov, input logic ud,
                         input logic [7:0] d);
    chk({p, " count"}, 32'(count), 32'(c));
    chk({p, " full"}, 32'(full), 32'(f));
    chk({p, " empty"}, 32'(empty), 32'(e));
    chk({p, " almost_full"}, 32'(almost_full), 32'(af));
    chk({p, " almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({p, " overflow"}, 32'(overflow), 32'(ov));
    chk({p, " underflow"}, 32'(underflow), 32'(ud));
    chk({p, " dout"}, 32'(dout), 32'(d));
  endtask

  // Called at a negative edge: drive, take one rising edge, return at the next negative edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; din = d; rd = r; clr_err = c;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = 8'h00;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] s, input logic [7:0] f);
`ifdef FIFO_SYNC_V2_FWFT_EN
    return f;
`else
    return s;
`endif
  endfunction

  initial begin
    logic [7:0] bases[3];
    logic [7:0] q[$];
    logic [7:0] popped;
    logic [7:0] head;

    //          wr    din    rd    clr   cnt   full  empty af    ae    ovf   udf   dstd   dfw
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 8'h33};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 8'h00};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 8'h00};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h00};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h00};
    vt[13] = '{1'b1, 8'h77, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h77};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      cyc(vt[i].wr, vt[i].din, vt[i].rd, vt[i].clr);
      chk_all($sformatf("vec%0d", i), vt[i].cnt, vt[i].full, vt[i].empty, vt[i].af,
              vt[i].ae, vt[i].ovf, vt[i].udf, pick(vt[i].dstd, vt[i].dfw));
    end

    // Full-FIFO simultaneous push/pop plus pointer wrap over three fill/drain rounds.
    bases[0] = 8'h62; bases[1] = 8'hA0; bases[2] = 8'hC0;
    for (int c = 0; c < 3; c++) begin
      q.delete();
      for (int k = 0; k < 4; k++) begin
        cyc(1'b1, bases[c] + 8'(k), 1'b0, 1'b0);
        q.push_back(bases[c] + 8'(k));
      end
      chk($sformatf("wrap%0d full", c), 32'(full), 32'd1);
      cyc(1'b1, bases[c] + 8'd4, 1'b1, 1'b0);
      popped = q.pop_front();
      q.push_back(bases[c] + 8'd4);
      chk($sformatf("wrap%0d rdwr count", c), 32'(count), 32'd4);
      chk($sformatf("wrap%0d rdwr overflow", c), 32'(overflow), 32'd0);
      chk($sformatf("wrap%0d rdwr dout", c), 32'(dout), 32'(pick(popped, q[0])));
      for (int k = 0; k < 4; k++) begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        popped = q.pop_front();
        head = (q.size() > 0) ? q[0] : 8'h00;
        chk($sformatf("wrap%0d drain%0d dout", c, k), 32'(dout), 32'(pick(popped, head)));
      end
      chk($sformatf("wrap%0d empty", c), 32'(empty), 32'd1);
      chk($sformatf("wrap%0d underflow", c), 32'(underflow), 32'd0);
    end

    // Asynchronous reset in the middle of a cycle with two words stored.
    cyc(1'b1, 8'h91, 1'b0, 1'b0);
    cyc(1'b1, 8'h92, 1'b1, 1'b0);
    cyc(1'b1, 8'h93, 1'b0, 1'b0);
    cyc(1'b1, 8'h94, 1'b0, 1'b0);
    chk("pre-reset count", 32'(count), 32'd3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre-reset count2", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1 chk_all("async reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("post-reset rd", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 8'h88, 1'b0, 1'b0);
    chk_all("post-reset wr", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, pick(8'h00, 8'h88));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("post-reset readback", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, pick(8'h88, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
